// File: rtl/m_demultiplexor1_4_reg.sv
// Registered 1-to-4 demultiplexor: a single-entry buffer takes one word plus a destination
// select and presents it on exactly one of four valid/ready channels, counting deliveries per channel.
module m_demultiplexor1_4_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_select,
  output logic [WIDTH-1:0] o_d0,
  output logic [WIDTH-1:0] o_d1,
  output logic [WIDTH-1:0] o_d2,
  output logic [WIDTH-1:0] o_d3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       i_ready,
  output logic [CNT_W-1:0] o_cnt0,
  output logic [CNT_W-1:0] o_cnt1,
  output logic [CNT_W-1:0] o_cnt2,
  output logic [CNT_W-1:0] o_cnt3
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] data_r;
  logic [1:0]       sel_r;
  logic [CNT_W-1:0] cnt_r [4];

  logic             ready_s;
  logic             deliver_s;
  logic             in_xfer_s;
  logic [3:0]       valid_s;
  logic [WIDTH-1:0] d_s [4];

  // Saturating increment: a counter parked at all-ones never wraps back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a delivery with a new word waiting keeps the buffer full.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = IDLE;
        end
      end
      HOLD: begin
        if (deliver_s && !i_valid) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Handshake outputs; only the selected channel's ready is ever consulted.
  always_comb begin
    deliver_s = 1'b0;
    ready_s   = 1'b0;
    valid_s   = 4'b0000;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
      end
      HOLD: begin
        deliver_s       = i_ready[sel_r];
        ready_s         = i_ready[sel_r];
        valid_s[sel_r]  = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
    in_xfer_s = i_valid & ready_s;
  end

  // Data fan-out: non-selected channels are forced to zero.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      if (valid_s[n]) begin
        d_s[n] = data_r;
      end else begin
        d_s[n] = {WIDTH{1'b0}};
      end
    end
  end

  // Single-entry buffer; word and select are sampled only on an input transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_r <= {WIDTH{1'b0}};
      sel_r  <= 2'd0;
    end else if (in_xfer_s) begin
      data_r <= i_data;
      sel_r  <= i_select;
    end else begin
      data_r <= data_r;
      sel_r  <= sel_r;
    end
  end

  // Per-channel delivery counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n < 4; n++) begin
        cnt_r[n] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (valid_s[n] && i_ready[n]) begin
          cnt_r[n] <= sat_inc(cnt_r[n]);
        end else begin
          cnt_r[n] <= cnt_r[n];
        end
      end
    end
  end

  assign o_ready = ready_s;
  assign o_valid = valid_s;
  assign o_d0    = d_s[0];
  assign o_d1    = d_s[1];
  assign o_d2    = d_s[2];
  assign o_d3    = d_s[3];
  assign o_cnt0  = cnt_r[0];
  assign o_cnt1  = cnt_r[1];
  assign o_cnt2  = cnt_r[2];
  assign o_cnt3  = cnt_r[3];

endmodule

// File: tb/tb_m_demultiplexor1_4_reg.sv
// Directed bench for m_demultiplexor1_4_reg; a second instance with CNT_W=2 exercises saturation.
module tb_m_demultiplexor1_4_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_select;
  logic [3:0]  tgt_ready;

  logic        ready_a;
  logic [31:0] d0_a, d1_a, d2_a, d3_a;
  logic [3:0]  valid_a;
  logic [7:0]  cnt0_a, cnt1_a, cnt2_a, cnt3_a;

  logic        ready_b;
  logic [31:0] d0_b, d1_b, d2_b, d3_b;
  logic [3:0]  valid_b;
  logic [1:0]  cnt0_b, cnt1_b, cnt2_b, cnt3_b;

  int total;
  int bad;

  m_demultiplexor1_4_reg #(.WIDTH(32), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(ready_a),
    .i_data(in_data), .i_select(in_select),
    .o_d0(d0_a), .o_d1(d1_a), .o_d2(d2_a), .o_d3(d3_a),
    .o_valid(valid_a), .i_ready(tgt_ready),
    .o_cnt0(cnt0_a), .o_cnt1(cnt1_a), .o_cnt2(cnt2_a), .o_cnt3(cnt3_a)
  );

  m_demultiplexor1_4_reg #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(ready_b),
    .i_data(in_data), .i_select(in_select),
    .o_d0(d0_b), .o_d1(d1_b), .o_d2(d2_b), .o_d3(d3_b),
    .o_valid(valid_b), .i_ready(tgt_ready),
    .o_cnt0(cnt0_b), .o_cnt1(cnt1_b), .o_cnt2(cnt2_b), .o_cnt3(cnt3_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] s, input logic [3:0] r);
    in_valid  = v;
    in_data   = d;
    in_select = s;
    tgt_ready = r;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1. Reset state, then an asynchronous reset while a word is held
    chk("rst_ready", {31'd0, ready_a}, 32'd1);
    chk("rst_valid", {28'd0, valid_a}, 32'd0);
    drive(1'b1, 32'h5555_AAAA, 2'd1, 4'b0000);
    tick();
    drive(1'b0, 32'h0, 2'd0, 4'b0000);
    chk("hold_pre_rst_valid", {28'd0, valid_a}, 32'h2);
    chk("hold_pre_rst_d1", d1_a, 32'h5555_AAAA);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {28'd0, valid_a}, 32'd0);
    chk("async_rst_d1", d1_a, 32'd0);
    chk("async_rst_cnt1", {24'd0, cnt1_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 4'b1111);
    tick();
    chk("post_rst_ready", {31'd0, ready_a}, 32'd1);
    chk("post_rst_no_deliver", {24'd0, cnt1_a}, 32'd0);
    chk("post_rst_valid", {28'd0, valid_a}, 32'd0);

    // 2. Single word to channel 2
    drive(1'b1, 32'hDEAD_BEEF, 2'd2, 4'b0100);
    tick();
    drive(1'b0, 32'h0, 2'd0, 4'b0100);
    chk("single_valid", {28'd0, valid_a}, 32'h4);
    chk("single_d2", d2_a, 32'hDEAD_BEEF);
    chk("single_d0", d0_a, 32'd0);
    chk("single_d1", d1_a, 32'd0);
    chk("single_d3", d3_a, 32'd0);
    chk("single_ready", {31'd0, ready_a}, 32'd1);
    tick();
    chk("single_cnt2", {24'd0, cnt2_a}, 32'd1);
    chk("single_idle_valid", {28'd0, valid_a}, 32'd0);

    // 3. Backpressure on channel 1; new input must be ignored while stalled
    drive(1'b1, 32'h1111_1111, 2'd1, 4'b0000);
    tick();
    drive(1'b1, 32'h2222_2222, 2'd3, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {28'd0, valid_a}, 32'h2);
      chk("bp_ready", {31'd0, ready_a}, 32'd0);
      chk("bp_d1", d1_a, 32'h1111_1111);
      tick();
    end
    chk("bp_cnt1_stalled", {24'd0, cnt1_a}, 32'd0);
    drive(1'b0, 32'h0, 2'd0, 4'b0010);
    chk("bp_release_ready", {31'd0, ready_a}, 32'd1);
    tick();
    chk("bp_cnt1", {24'd0, cnt1_a}, 32'd1);
    chk("bp_idle_valid", {28'd0, valid_a}, 32'd0);

    // 4. Streaming to channels 0..3 with all targets ready
    drive(1'b1, 32'hA0A0_A0A0, 2'd0, 4'b1111);
    tick();
    chk("st_valid0", {28'd0, valid_a}, 32'h1);
    chk("st_d0", d0_a, 32'hA0A0_A0A0);
    drive(1'b1, 32'hB1B1_B1B1, 2'd1, 4'b1111);
    tick();
    chk("st_valid1", {28'd0, valid_a}, 32'h2);
    chk("st_d1", d1_a, 32'hB1B1_B1B1);
    chk("st_d0_cleared", d0_a, 32'd0);
    drive(1'b1, 32'hC2C2_C2C2, 2'd2, 4'b1111);
    tick();
    chk("st_valid2", {28'd0, valid_a}, 32'h4);
    chk("st_d2", d2_a, 32'hC2C2_C2C2);
    drive(1'b1, 32'hD3D3_D3D3, 2'd3, 4'b1111);
    tick();
    chk("st_valid3", {28'd0, valid_a}, 32'h8);
    chk("st_d3", d3_a, 32'hD3D3_D3D3);
    drive(1'b0, 32'h0, 2'd0, 4'b1111);
    tick();
    chk("st_end_valid", {28'd0, valid_a}, 32'd0);
    chk("st_cnt0", {24'd0, cnt0_a}, 32'd1);
    chk("st_cnt1", {24'd0, cnt1_a}, 32'd2);
    chk("st_cnt2", {24'd0, cnt2_a}, 32'd2);
    chk("st_cnt3", {24'd0, cnt3_a}, 32'd1);

    // 6. Ready on the wrong channels must not deliver
    drive(1'b1, 32'h0BAD_F00D, 2'd0, 4'b1110);
    tick();
    drive(1'b0, 32'h0, 2'd0, 4'b1110);
    chk("wc_ready", {31'd0, ready_a}, 32'd0);
    tick();
    chk("wc_valid_held", {28'd0, valid_a}, 32'h1);
    chk("wc_cnt0", {24'd0, cnt0_a}, 32'd1);
    chk("wc_cnt1", {24'd0, cnt1_a}, 32'd2);
    drive(1'b0, 32'h0, 2'd0, 4'b0001);
    tick();
    chk("wc_release_cnt0", {24'd0, cnt0_a}, 32'd2);
    chk("wc_release_valid", {28'd0, valid_a}, 32'd0);

    // 5. Saturation on channel 3 with a 2-bit counter
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h0000_0001, 2'd3, 4'b1111);
    tick();
    chk("sat_cnt_start", {30'd0, cnt3_b}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        drive(1'b1, 32'h0000_0002 + i, 2'd3, 4'b1111);
      end else begin
        drive(1'b0, 32'h0, 2'd0, 4'b1111);
      end
      tick();
      chk("sat_cnt3", {30'd0, cnt3_b}, (i < 2) ? (i + 1) : 32'd3);
    end
    chk("sat_wide_cnt3", {24'd0, cnt3_a}, 32'd5);
    chk("sat_end_valid", {28'd0, valid_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
